// File: rtl/stuff_or_data_pkg.sv
// Shared parameter defaults for the stuff/data slot generator.
package stuff_or_data_pkg;

    localparam int unsigned MPT_W_DEFAULT = 8;

endpackage

// File: rtl/sod_mod_acc.sv
// Modular accumulator step: acc_new = (acc + cm) mod pm, data slot when acc_new < cm.
module sod_mod_acc
    import stuff_or_data_pkg::*;
#(
    parameter int unsigned MPT_W = MPT_W_DEFAULT
) (
    input  logic [MPT_W-1:0] acc_i,
    input  logic [MPT_W-1:0] cm_i,
    input  logic [MPT_W-1:0] pm_i,
    output logic [MPT_W-1:0] acc_c_o,
    output logic             ds_c_o
);

    localparam int unsigned SUM_W = MPT_W + 1;

    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] diff_c;

    // acc < pm and cm <= pm keep sum below 2*pm, so one conditional subtract suffices
    always_comb begin
        sum_c   = SUM_W'(acc_i) + SUM_W'(cm_i);
        diff_c  = sum_c - SUM_W'(pm_i);
        acc_c_o = (sum_c >= SUM_W'(pm_i)) ? MPT_W'(diff_c) : MPT_W'(sum_c);
        ds_c_o  = (acc_c_o < cm_i);
    end

endmodule

// File: rtl/stuff_or_data.sv
// Spreads cm data slots evenly across each pm-word frame and flags sof/length errors.
module stuff_or_data
    import stuff_or_data_pkg::*;
#(
    parameter int unsigned MPT_W = MPT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MPT_W-1:0] pm,
    input  logic [MPT_W-1:0] cm,
    input  logic             sof,
    input  logic             valid_in,
    output logic             sof_out,
    output logic             valid_out,
    output logic             ds,
    output logic             err_sof_early,
    output logic             err_sof_late,
    output logic             input_err
);

    logic             in_frame_q, in_frame_d;
    logic [MPT_W-1:0] acc_q, acc_d;
    logic [MPT_W-1:0] j_q, j_d;
    logic [MPT_W-1:0] pm_l_q, pm_l_d;
    logic [MPT_W-1:0] cm_l_q, cm_l_d;

    logic sof_out_q, sof_out_d;
    logic valid_out_q, valid_out_d;
    logic ds_q, ds_d;
    logic err_early_q, err_early_d;
    logic err_late_q, err_late_d;
    logic input_err_q, input_err_d;

    logic             start_c;
    logic             illegal_c;
    logic             last_c;
    logic [MPT_W-1:0] pm_use_c;
    logic [MPT_W-1:0] cm_use_c;
    logic [MPT_W-1:0] acc_prev_c;
    logic [MPT_W-1:0] j_cur_c;
    logic [MPT_W-1:0] acc_new_c;
    logic             ds_new_c;

    // A frame start runs on the live lengths from a clean accumulator
    always_comb begin
        start_c    = valid_in & ~in_frame_q;
        pm_use_c   = start_c ? pm : pm_l_q;
        cm_use_c   = start_c ? cm : cm_l_q;
        acc_prev_c = start_c ? '0 : acc_q;
        j_cur_c    = start_c ? MPT_W'(1) : j_q;
        illegal_c  = start_c & ((pm == '0) | (cm == '0) | (cm > pm));
        last_c     = (j_cur_c == pm_use_c);
    end

    sod_mod_acc #(
        .MPT_W (MPT_W)
    ) u_mod_acc (
        .acc_i   (acc_prev_c),
        .cm_i    (cm_use_c),
        .pm_i    (pm_use_c),
        .acc_c_o (acc_new_c),
        .ds_c_o  (ds_new_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame_q  <= 1'b0;
            acc_q       <= '0;
            j_q         <= MPT_W'(1);
            pm_l_q      <= '0;
            cm_l_q      <= '0;
            sof_out_q   <= 1'b0;
            valid_out_q <= 1'b0;
            ds_q        <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            input_err_q <= 1'b0;
        end else begin
            in_frame_q  <= in_frame_d;
            acc_q       <= acc_d;
            j_q         <= j_d;
            pm_l_q      <= pm_l_d;
            cm_l_q      <= cm_l_d;
            sof_out_q   <= sof_out_d;
            valid_out_q <= valid_out_d;
            ds_q        <= ds_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
            input_err_q <= input_err_d;
        end
    end

    // Frame progress; an illegal start word leaves everything untouched
    always_comb begin
        in_frame_d = in_frame_q;
        acc_d      = acc_q;
        j_d        = j_q;
        pm_l_d     = pm_l_q;
        cm_l_d     = cm_l_q;
        if (valid_in && !illegal_c) begin
            pm_l_d = pm_use_c;
            cm_l_d = cm_use_c;
            if (last_c) begin
                in_frame_d = 1'b0;
                acc_d      = '0;
                j_d        = MPT_W'(1);
            end else begin
                in_frame_d = 1'b1;
                acc_d      = acc_new_c;
                j_d        = j_cur_c + MPT_W'(1);
            end
        end
    end

    always_comb begin
        sof_out_d   = 1'b0;
        valid_out_d = 1'b0;
        ds_d        = 1'b0;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        input_err_d = 1'b0;
        if (valid_in) begin
            valid_out_d = 1'b1;
            sof_out_d   = sof;
            ds_d        = ds_new_c & ~illegal_c;
            err_early_d = sof & ~start_c;
            err_late_d  = ~sof & start_c;
            input_err_d = illegal_c;
        end
    end

    assign sof_out       = sof_out_q;
    assign valid_out     = valid_out_q;
    assign ds            = ds_q;
    assign err_sof_early = err_early_q;
    assign err_sof_late  = err_late_q;
    assign input_err     = input_err_q;

endmodule

// File: tb/tb_stuff_or_data.sv
// Directed bench for stuff_or_data: hand-computed ds/error sequences per word.
module tb_stuff_or_data;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pm;
    logic [W-1:0] cm;
    logic         sof;
    logic         valid_in;
    logic         sof_out;
    logic         valid_out;
    logic         ds;
    logic         err_sof_early;
    logic         err_sof_late;
    logic         input_err;

    int n_cmp  = 0;
    int n_fail = 0;

    stuff_or_data #(.MPT_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .pm            (pm),
        .cm            (cm),
        .sof           (sof),
        .valid_in      (valid_in),
        .sof_out       (sof_out),
        .valid_out     (valid_out),
        .ds            (ds),
        .err_sof_early (err_sof_early),
        .err_sof_late  (err_sof_late),
        .input_err     (input_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Apply one slot, clock it, then check every output 1 ns after the edge
    task automatic word(input string tag, input logic r, input logic v, input logic s,
                        input int p, input int c, input logic e_ds,
                        input logic e_early, input logic e_late, input logic e_ierr);
        rst      = r;
        valid_in = v;
        sof      = s;
        pm       = W'(p);
        cm       = W'(c);
        @(posedge clk);
        #1;
        chk({tag, ".ds"},        ds,            e_ds);
        chk({tag, ".valid_out"}, valid_out,     v & ~r);
        chk({tag, ".sof_out"},   sof_out,       s & v & ~r);
        chk({tag, ".early"},     err_sof_early, e_early);
        chk({tag, ".late"},      err_sof_late,  e_late);
        chk({tag, ".ierr"},      input_err,     e_ierr);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; sof = 1'b0; pm = '0; cm = '0;
        @(posedge clk); #1;
        // reset overrides a valid word in the same cycle
        word("rst0", 1, 1, 1, 5, 2, 0, 0, 0, 0);

        // pm=5 cm=2 -> 0,0,1,0,1
        word("f5a.1", 0, 1, 1, 5, 2, 0, 0, 0, 0);
        word("f5a.2", 0, 1, 0, 5, 2, 0, 0, 0, 0);
        word("f5a.3", 0, 1, 0, 5, 2, 1, 0, 0, 0);
        word("f5a.4", 0, 1, 0, 5, 2, 0, 0, 0, 0);
        word("f5a.5", 0, 1, 0, 5, 2, 1, 0, 0, 0);

        // pm=7 cm=3 with gaps; live pm/cm changed mid-frame must be ignored
        word("f7.1",  0, 1, 1, 7, 3, 0, 0, 0, 0);
        word("f7.g1", 0, 0, 1, 2, 2, 0, 0, 0, 0);
        word("f7.2",  0, 1, 0, 2, 2, 0, 0, 0, 0);
        word("f7.3",  0, 1, 0, 2, 2, 1, 0, 0, 0);
        word("f7.g2", 0, 0, 0, 9, 1, 0, 0, 0, 0);
        word("f7.g3", 0, 0, 1, 9, 1, 0, 0, 0, 0);
        word("f7.4",  0, 1, 0, 1, 1, 0, 0, 0, 0);
        word("f7.5",  0, 1, 0, 7, 3, 1, 0, 0, 0);
        word("f7.g4", 0, 0, 0, 7, 3, 0, 0, 0, 0);
        word("f7.6",  0, 1, 0, 7, 3, 0, 0, 0, 0);
        word("f7.7",  0, 1, 0, 7, 3, 1, 0, 0, 0);

        // pm=4 cm=4 all data, then pm=3 cm=2 started without sof
        word("f4.1",  0, 1, 1, 4, 4, 1, 0, 0, 0);
        word("f4.2",  0, 1, 0, 4, 4, 1, 0, 0, 0);
        word("f4.3",  0, 1, 0, 4, 4, 1, 0, 0, 0);
        word("f4.4",  0, 1, 0, 4, 4, 1, 0, 0, 0);
        word("f3.1",  0, 1, 0, 3, 2, 0, 0, 1, 0);
        word("f3.2",  0, 1, 0, 3, 2, 1, 0, 0, 0);
        word("f3.3",  0, 1, 0, 3, 2, 1, 0, 0, 0);

        // sof held high: early error on words 2..5, ds unchanged
        word("f5b.1", 0, 1, 1, 5, 2, 0, 0, 0, 0);
        word("f5b.2", 0, 1, 1, 5, 2, 0, 1, 0, 0);
        word("f5b.3", 0, 1, 1, 5, 2, 1, 1, 0, 0);
        word("f5b.4", 0, 1, 1, 5, 2, 0, 1, 0, 0);
        word("f5b.5", 0, 1, 1, 5, 2, 1, 1, 0, 0);

        // illegal starts (cm>pm, pm=0, cm=0) then a legal pm=3 cm=1 frame
        word("ill.cm>pm", 0, 1, 1, 3, 5, 0, 0, 0, 1);
        word("ill.pm0",   0, 1, 1, 0, 0, 0, 0, 0, 1);
        word("ill.cm0",   0, 1, 1, 4, 0, 0, 0, 0, 1);
        word("f3b.1",     0, 1, 1, 3, 1, 0, 0, 0, 0);
        word("f3b.2",     0, 1, 0, 3, 1, 0, 0, 0, 0);
        word("f3b.3",     0, 1, 0, 3, 1, 1, 0, 0, 0);

        // one-word frames with sof every word
        word("f1.1", 0, 1, 1, 1, 1, 1, 0, 0, 0);
        word("f1.2", 0, 1, 1, 1, 1, 1, 0, 0, 0);
        word("f1.3", 0, 1, 1, 1, 1, 1, 0, 0, 0);

        // reset after word 2 abandons the frame; next word restarts at j=1
        word("f5c.1",  0, 1, 1, 5, 2, 0, 0, 0, 0);
        word("f5c.2",  0, 1, 0, 5, 2, 0, 0, 0, 0);
        word("f5c.rst", 1, 1, 1, 5, 2, 0, 0, 0, 0);
        word("f5d.1",  0, 1, 1, 5, 2, 0, 0, 0, 0);
        word("f5d.2",  0, 1, 0, 5, 2, 0, 0, 0, 0);
        word("f5d.3",  0, 1, 0, 5, 2, 1, 0, 0, 0);
        word("f5d.4",  0, 1, 0, 5, 2, 0, 0, 0, 0);
        word("f5d.5",  0, 1, 0, 5, 2, 1, 0, 0, 0);
        word("idle",   0, 0, 0, 5, 2, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stuff_or_data.md
STUFF_OR_DATA -- requirements
Module: stuff_or_data

Interface
REQ-001 Parameter MPT_W, default 8: width of the packet-length (pm) and data-count (cm) fields.
REQ-002 Ports, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- pm  in  MPT_W  words per frame (frame period).
- cm  in  MPT_W  data words per frame.
- sof  in  1  start-of-frame marker, qualified by valid_in.
- valid_in  in  1  input word slot valid.
- sof_out  out  1  registered sof&valid_in.
- valid_out  out  1  registered valid_in.
- ds  out  1  1 = data slot, 0 = stuff slot.
- err_sof_early  out  1  sof arrived mid-frame (one-cycle pulse).
- err_sof_late  out  1  frame started without sof (one-cycle pulse).
- input_err  out  1  illegal pm/cm at frame start (one-cycle pulse).

Function
REQ-003 All outputs are registered; latency 1 clock from the sampled valid_in word to its outputs.
REQ-004 Cycle with valid_in=0: next-cycle ds, valid_out, sof_out and all error outputs are 0; internal state holds.
REQ-005 Internal state: word index j (1..pm, MPT_W bits), accumulator acc (MPT_W bits, acc < pm), latched pm_l/cm_l, flag in_frame.
REQ-006 Frame start = valid word while in_frame=0; it uses live pm/cm, latches them into pm_l/cm_l, and treats acc_prev = 0, j = 1.
REQ-007 Each valid word: sum = acc_prev + cm (MPT_W+1 bits); acc_new = sum - pm if sum >= pm, else sum; ds = (acc_new < cm). Net effect: ds for word j = ((j*cm) mod pm) < cm.
REQ-008 Mid-frame words use pm_l/cm_l; live pm/cm are ignored until the next frame start.
REQ-009 Over one frame, exactly cm words have ds=1, evenly spread; the last word (j=pm) always has ds=1.
REQ-010 On word j = pm_l, frame ends: in_frame <- 0, acc <- 0; the next valid word is a frame start.
REQ-011 sof=1 on a valid mid-frame word: err_sof_early=1 for that word; sof is otherwise ignored and the frame continues (no restart).
REQ-012 sof=0 on a valid frame-start word: err_sof_late=1 for that word; the frame still starts.
REQ-013 At frame start, pm==0 or cm==0 or cm>pm makes the word illegal:
- input_err=1 and ds=0 for that word.
- in_frame stays 0; no state is updated.
REQ-014 pm=1, cm=1 is legal: a one-word frame with ds=1; sof each word raises no error.
REQ-015 valid_out and sof_out track valid_in and sof&valid_in independent of frame state and errors.

Reset
REQ-016 rst=1 at a rising edge clears all outputs to 0 and sets in_frame=0, acc=0, j=1, pm_l=cm_l=0; this overrides valid_in in the same cycle.
REQ-017 Reset mid-frame abandons the frame; the first valid word after reset is a frame start.

Structure
REQ-018 Single module, no sub-modules required; the modular add/compare may optionally be a small sub-module named sod_mod_acc.
REQ-019 The shared package holds only the MPT_W default; no typedefs are needed.

Verification
REQ-020 pm=5, cm=2, sof on first word, 5 consecutive valid words -> ds 0,0,1,0,1; valid_out=1 each; no errors.
REQ-021 pm=7, cm=3, valid_in randomly gapped -> on valid words ds 0,0,1,0,1,0,1; on gap cycles ds=0 and valid_out=0.
REQ-022 pm=4, cm=4 -> ds 1,1,1,1; then a new frame with pm=3, cm=2 without sof -> err_sof_late=1 on its first word, ds 0,1,1.
REQ-023 pm=5, cm=2 frame with sof=1 held on every word -> err_sof_early=1 on words 2-5, ds sequence unchanged 0,0,1,0,1.
REQ-024 Frame start with pm=3, cm=5 -> input_err=1, ds=0; next word with pm=3, cm=1 starts a frame: ds 0,0,1.
REQ-025 Assert rst after word 2 of a pm=5 frame -> all outputs 0; the next valid word restarts at j=1.
